imuldiv_intmuldiviterativeparam: RTL and testbench

Parametrised iterative integer multiply/divide unit, the next generation of the 32-bit iterative mul/div unit. It supports any operand width NBITS and adds unsigned multiply. Divide-by-zero and signed-overflow requests have defined results and take a 1-cycle fast path. It sits behind the processor's val/rdy muldiv request/response ports and is a drop-in replacement at NBITS=32.

---
 rtl/imuldiv_intmuldiviterativeparam_pkg.sv | 29 ++
 rtl/imuldiv_intmuldiviterativeparam_if.sv | 23 ++
 rtl/imuldiv_intmuldiviterativeparam_dpath.sv | 135 +++++++++++++
 rtl/imuldiv_intmuldiviterativeparam.sv | 66 ++++++
 tb/tb_imuldiv_intmuldiviterativeparam.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/imuldiv_intmuldiviterativeparam_pkg.sv
// rtl/imuldiv_intmuldiviterativeparam_pkg.sv - muldiv function codes, FSM states and fn decode helpers
package imuldiv_intmuldiviterativeparam_pkg;

    localparam logic [2:0] FN_MUL  = 3'd0;
    localparam logic [2:0] FN_DIV  = 3'd1;
    localparam logic [2:0] FN_DIVU = 3'd2;
    localparam logic [2:0] FN_REM  = 3'd3;
    localparam logic [2:0] FN_REMU = 3'd4;
    localparam logic [2:0] FN_MULU = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic logic fn_is_signed(input logic [2:0] fn);
        return (fn == FN_MUL) || (fn == FN_DIV) || (fn == FN_REM);
    endfunction

    function automatic logic fn_is_mul(input logic [2:0] fn);
        return (fn == FN_MUL) || (fn == FN_MULU);
    endfunction

    function automatic logic fn_is_div(input logic [2:0] fn);
        return (fn >= FN_DIV) && (fn <= FN_REMU);
    endfunction

endpackage

// File: rtl/imuldiv_intmuldiviterativeparam_if.sv
// rtl/imuldiv_intmuldiviterativeparam_if.sv - val/rdy muldiv request/response bundle
interface imuldiv_intmuldiviterativeparam_if #(
    parameter int NBITS = 32
);
    logic [2:0]         muldivreq_msg_fn;
    logic [NBITS-1:0]   muldivreq_msg_a;
    logic [NBITS-1:0]   muldivreq_msg_b;
    logic               muldivreq_val;
    logic               muldivreq_rdy;
    logic [2*NBITS-1:0] muldivresp_msg_result;
    logic               muldivresp_val;
    logic               muldivresp_rdy;

    modport master (
        output muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b, muldivreq_val, muldivresp_rdy,
        input  muldivreq_rdy, muldivresp_msg_result, muldivresp_val
    );

    modport slave (
        input  muldivreq_msg_fn, muldivreq_msg_a, muldivreq_msg_b, muldivreq_val, muldivresp_rdy,
        output muldivreq_rdy, muldivresp_msg_result, muldivresp_val
    );
endinterface

// File: rtl/imuldiv_intmuldiviterativeparam_dpath.sv
// rtl/imuldiv_intmuldiviterativeparam_dpath.sv - operand/accumulator/counter registers, shift-add/restoring step, sign fixup
module imuldiv_intmuldiviterativeparam_dpath
    import imuldiv_intmuldiviterativeparam_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2:0]         fn_i,
    input  logic [NBITS-1:0]   a_i,
    input  logic [NBITS-1:0]   b_i,
    input  logic               load_i,
    input  logic               calc_i,
    input  logic               clr_i,
    output logic               fast_o,
    output logic               last_o,
    output logic [2*NBITS-1:0] result_o
);
    localparam int CW = $clog2(NBITS + 1);
    localparam logic [NBITS-1:0] MIN_NEG = {1'b1, {(NBITS-1){1'b0}}};

    logic [2:0]         fn_q, fn_d;
    logic               sign_a_q, sign_a_d, sign_b_q, sign_b_d;
    logic [NBITS-1:0]   a_q, a_d, b_q, b_d;
    logic [2*NBITS-1:0] acc_q, acc_d, res_q, res_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic               sa_in, sb_in;
    logic [NBITS-1:0]   a_mag, b_mag;
    logic [2*NBITS-1:0] fast_res, step, fixed;
    logic [NBITS:0]     rem_sh, diff;
    logic [NBITS-1:0]   quot, rem;

    // Fast-path decode works on the raw operands, before magnitude conversion.
    always_comb begin
        sa_in    = fn_is_signed(fn_i) & a_i[NBITS-1];
        sb_in    = fn_is_signed(fn_i) & b_i[NBITS-1];
        a_mag    = sa_in ? -a_i : a_i;
        b_mag    = sb_in ? -b_i : b_i;
        fast_o   = 1'b0;
        fast_res = '0;
        if (fn_is_div(fn_i) && (b_i == '0)) begin
            fast_o   = 1'b1;
            fast_res = {a_i, {NBITS{1'b1}}};
        end else if (((fn_i == FN_DIV) || (fn_i == FN_REM)) && (a_i == MIN_NEG) && (b_i == '1)) begin
            fast_o   = 1'b1;
            fast_res = {{NBITS{1'b0}}, a_i};
        end else if (fn_i > FN_MULU) begin
            fast_o   = 1'b1;
        end
    end

    // Multiply walks B MSB-first; divide keeps {rem, dividend/quot} in acc.
    always_comb begin
        rem_sh = {acc_q[2*NBITS-1:NBITS], acc_q[NBITS-1]};
        diff   = rem_sh - {1'b0, b_q};
        if (fn_is_mul(fn_q))
            step = {acc_q[2*NBITS-2:0], 1'b0} + (b_q[NBITS-1] ? {{NBITS{1'b0}}, a_q} : '0);
        else if (diff[NBITS])
            step = {rem_sh[NBITS-1:0], acc_q[NBITS-2:0], 1'b0};
        else
            step = {diff[NBITS-1:0], acc_q[NBITS-2:0], 1'b1};

        quot  = step[NBITS-1:0];
        rem   = step[2*NBITS-1:NBITS];
        fixed = step;
        if (fn_is_mul(fn_q)) begin
            if (sign_a_q ^ sign_b_q)
                fixed = -step;
        end else begin
            if (sign_a_q ^ sign_b_q)
                quot = -quot;
            if (sign_a_q)
                rem = -rem;
            fixed = {rem, quot};
        end
    end

    always_comb begin
        fn_d     = fn_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        res_d    = res_q;
        if (load_i) begin
            fn_d     = fn_i;
            sign_a_d = sa_in;
            sign_b_d = sb_in;
            a_d      = a_mag;
            b_d      = b_mag;
            acc_d    = fn_is_mul(fn_i) ? '0 : {{NBITS{1'b0}}, a_mag};
            cnt_d    = CW'(NBITS - 1);
            res_d    = fast_res;
        end else if (calc_i) begin
            acc_d = step;
            if (fn_is_mul(fn_q))
                b_d = {b_q[NBITS-2:0], 1'b0};
            if (cnt_q == '0)
                res_d = fixed;
            else
                cnt_d = cnt_q - CW'(1);
        end else if (clr_i) begin
            res_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fn_q     <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
        end else begin
            fn_q     <= fn_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            res_q    <= res_d;
        end
    end

    assign last_o   = (cnt_q == '0);
    assign result_o = res_q;

endmodule

// File: rtl/imuldiv_intmuldiviterativeparam.sv
// rtl/imuldiv_intmuldiviterativeparam.sv - iterative NBITS mul/div unit: IDLE/CALC/DONE FSM and val/rdy handshake
module imuldiv_intmuldiviterativeparam
    import imuldiv_intmuldiviterativeparam_pkg::*;
#(
    parameter int NBITS = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    imuldiv_intmuldiviterativeparam_if.slave  io
);
    state_e state_q, state_d;
    logic   fire, fast, last, load, calc, clr;

    assign io.muldivreq_rdy  = (state_q == ST_IDLE);
    assign io.muldivresp_val = (state_q == ST_DONE);
    assign fire              = io.muldivreq_val && io.muldivreq_rdy;

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        calc    = 1'b0;
        clr     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fire) begin
                    load    = 1'b1;
                    state_d = fast ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                calc = 1'b1;
                if (last)
                    state_d = ST_DONE;
            end
            ST_DONE: begin
                if (io.muldivresp_rdy) begin
                    clr     = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    imuldiv_intmuldiviterativeparam_dpath #(.NBITS(NBITS)) u_dpath (
        .clk      (clk),
        .reset    (reset),
        .fn_i     (io.muldivreq_msg_fn),
        .a_i      (io.muldivreq_msg_a),
        .b_i      (io.muldivreq_msg_b),
        .load_i   (load),
        .calc_i   (calc),
        .clr_i    (clr),
        .fast_o   (fast),
        .last_o   (last),
        .result_o (io.muldivresp_msg_result)
    );

endmodule

// File: tb/tb_imuldiv_intmuldiviterativeparam.sv
// tb/tb_imuldiv_intmuldiviterativeparam.sv - self-checking bench for the 32-bit and 8-bit mul/div units
module tb_imuldiv_intmuldiviterativeparam;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    imuldiv_intmuldiviterativeparam_if #(.NBITS(32)) if32 ();
    imuldiv_intmuldiviterativeparam_if #(.NBITS(8))  if8 ();

    imuldiv_intmuldiviterativeparam #(.NBITS(32)) dut32 (.clk(clk), .reset(reset), .io(if32.slave));
    imuldiv_intmuldiviterativeparam #(.NBITS(8))  dut8  (.clk(clk), .reset(reset), .io(if8.slave));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: signed/unsigned arithmetic straight from the function definitions.
    function automatic logic [63:0] ref_op(input int nb, input logic [2:0] fn,
                                           input logic [31:0] a, input logic [31:0] b);
        logic [63:0] mask, mask2;
        longint ua, ub, sa, sb, q, r;
        mask  = (64'd1 << nb) - 64'd1;
        mask2 = (64'd1 << (2 * nb)) - 64'd1;
        ua = longint'(a & mask[31:0]);
        ub = longint'(b & mask[31:0]);
        sa = a[nb-1] ? ua - (longint'(1) << nb) : ua;
        sb = b[nb-1] ? ub - (longint'(1) << nb) : ub;
        case (fn)
            3'd0: return 64'(sa * sb) & mask2;
            3'd5: return 64'(ua * ub) & mask2;
            3'd1, 3'd2, 3'd3, 3'd4: begin
                if (ub == 0) begin
                    q = longint'(mask);
                    r = ua;
                end else if ((fn == 3'd1 || fn == 3'd3) && sa == -(longint'(1) << (nb - 1)) && sb == -1) begin
                    q = ua;
                    r = 0;
                end else if (fn == 3'd1 || fn == 3'd3) begin
                    q = sa / sb;
                    r = sa % sb;
                end else begin
                    q = ua / ub;
                    r = ua % ub;
                end
                return ((64'(r) & mask) << nb) | (64'(q) & mask);
            end
            default: return 64'd0;
        endcase
    endfunction

    function automatic bit ref_fast(input int nb, input logic [2:0] fn,
                                    input logic [31:0] a, input logic [31:0] b);
        logic [31:0] m;
        m = 32'((64'd1 << nb) - 64'd1);
        if (fn >= 3'd6) return 1'b1;
        if (fn >= 3'd1 && fn <= 3'd4 && (b & m) == 32'd0) return 1'b1;
        if ((fn == 3'd1 || fn == 3'd3) && (a & m) == (32'd1 << (nb - 1)) && (b & m) == m) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive(input bit w8, input logic val, input logic [2:0] fn,
                         input logic [31:0] a, input logic [31:0] b);
        if (w8) begin
            if8.muldivreq_val    = val;
            if8.muldivreq_msg_fn = fn;
            if8.muldivreq_msg_a  = a[7:0];
            if8.muldivreq_msg_b  = b[7:0];
        end else begin
            if32.muldivreq_val    = val;
            if32.muldivreq_msg_fn = fn;
            if32.muldivreq_msg_a  = a;
            if32.muldivreq_msg_b  = b;
        end
    endtask

    task automatic set_resp_rdy(input bit w8, input logic v);
        if (w8) if8.muldivresp_rdy = v;
        else    if32.muldivresp_rdy = v;
    endtask

    function automatic logic get_req_rdy(input bit w8);
        return w8 ? if8.muldivreq_rdy : if32.muldivreq_rdy;
    endfunction

    function automatic logic get_resp_val(input bit w8);
        return w8 ? if8.muldivresp_val : if32.muldivresp_val;
    endfunction

    function automatic logic [63:0] get_result(input bit w8);
        return w8 ? {48'd0, if8.muldivresp_msg_result} : if32.muldivresp_msg_result;
    endfunction

    task automatic run_op(input bit w8, input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int hold, input int gap, input string tag);
        int          nb, exp_lat, lat, k;
        bit          rdy_ok, hold_ok;
        logic [63:0] res;
        nb      = w8 ? 8 : 32;
        exp_lat = ref_fast(nb, fn, a, b) ? 1 : nb + 1;
        rdy_ok  = 1'b1;
        hold_ok = 1'b1;
        for (int g = 0; g < gap; g++) begin
            drive(w8, 1'b0, 3'($urandom), $urandom, $urandom);
            tick();
        end
        k = 0;
        while (!get_req_rdy(w8) && k < 200) begin
            tick();
            k++;
        end
        chk({tag, " req_rdy"}, 64'(get_req_rdy(w8)), 64'd1);
        drive(w8, 1'b1, fn, a, b);
        tick();
        lat = 1;
        while (!get_resp_val(w8) && lat < 200) begin
            if (get_req_rdy(w8)) rdy_ok = 1'b0;
            drive(w8, 1'($urandom), 3'($urandom), $urandom, $urandom);
            tick();
            lat++;
        end
        chk({tag, " latency"}, 64'(lat), 64'(exp_lat));
        res = get_result(w8);
        chk({tag, " result"}, res, exp);
        for (int h = 0; h < hold; h++) begin
            drive(w8, 1'($urandom), 3'($urandom), $urandom, $urandom);
            tick();
            if (!get_resp_val(w8) || get_req_rdy(w8) || get_result(w8) !== res) hold_ok = 1'b0;
        end
        chk({tag, " busy/hold"}, 64'({rdy_ok, hold_ok}), 64'd3);
        drive(w8, 1'b0, 3'd0, 32'd0, 32'd0);
        set_resp_rdy(w8, 1'b1);
        tick();
        set_resp_rdy(w8, 1'b0);
        chk({tag, " after handshake"},
            {61'd0, get_resp_val(w8), get_req_rdy(w8), (get_result(w8) == 64'd0)}, 64'b011);
    endtask

    initial begin
        logic [2:0]  fn;
        logic [31:0] a, b;
        bit          w8;
        reset = 1'b1;
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        drive(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
        set_resp_rdy(1'b0, 1'b0);
        set_resp_rdy(1'b1, 1'b0);
        tick();
        tick();
        tick();
        reset = 1'b0;
        chk("reset32", {61'd0, if32.muldivreq_rdy, if32.muldivresp_val, (if32.muldivresp_msg_result == 64'd0)}, 64'b101);
        chk("reset8",  {61'd0, if8.muldivreq_rdy,  if8.muldivresp_val,  (if8.muldivresp_msg_result == 16'd0)},  64'b101);

        run_op(1'b0, 3'd0, 32'hdeadbeef, 32'h10000000, 64'hfdeadbee_f0000000, 0, 0, "mul32");
        run_op(1'b0, 3'd1, 32'h0a01b044, 32'hffffb14a, 64'h00003372_ffffdf75, 2, 1, "div32");
        run_op(1'b0, 3'd2, 32'hfffffffb, 32'h00000064, 64'h0000005b_028f5c28, 0, 0, "divu32");
        run_op(1'b0, 3'd4, 32'hdeadbeef, 32'h0000beef, 64'h0000227f_00012a90, 1, 0, "remu32");
        run_op(1'b0, 3'd5, 32'hffffffff, 32'hffffffff, 64'hfffffffe_00000001, 0, 2, "mulu32");
        run_op(1'b0, 3'd1, 32'h00000007, 32'h00000000, 64'h00000007_ffffffff, 0, 0, "div0");
        run_op(1'b0, 3'd2, 32'h80000000, 32'h00000000, 64'h80000000_ffffffff, 3, 0, "divu0");
        run_op(1'b0, 3'd1, 32'h80000000, 32'hffffffff, 64'h00000000_80000000, 0, 0, "divovf");
        run_op(1'b0, 3'd6, 32'h12345678, 32'h9abcdef0, 64'd0, 0, 0, "fn6");
        run_op(1'b1, 3'd0, 32'hf8, 32'h08, 64'hffc0, 0, 0, "mul8");
        run_op(1'b1, 3'd3, 32'hf9, 32'h03, 64'hfffe, 1, 0, "rem8");
        run_op(1'b1, 3'd2, 32'hff, 32'h02, 64'h017f, 0, 1, "divu8");

        for (int i = 0; i < 40; i++) begin
            w8 = i[0];
            fn = 3'($urandom);
            a  = $urandom;
            b  = $urandom;
            if ($urandom_range(0, 7) == 0) b = 32'd0;
            if ($urandom_range(0, 15) == 0) begin
                a = w8 ? 32'h80 : 32'h80000000;
                b = w8 ? 32'hff : 32'hffffffff;
            end
            if (w8) begin
                a = a & 32'hff;
                b = b & 32'hff;
            end
            run_op(w8, fn, a, b, ref_op(w8 ? 8 : 32, fn, a, b),
                   $urandom_range(0, 20), $urandom_range(0, 3), $sformatf("rnd%0d", i));
        end

        // Abort a divide partway through CALC.
        drive(1'b0, 1'b1, 3'd1, 32'd100, 32'd7);
        tick();
        drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
        for (int i = 0; i < 4; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset", {61'd0, if32.muldivreq_rdy, if32.muldivresp_val, (if32.muldivresp_msg_result == 64'd0)}, 64'b101);
        run_op(1'b0, 3'd0, 32'd3, 32'd8, 64'h18, 0, 0, "mul_after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
